nibble_serial_tx: RTL
=====================

// Module: nibble_serial_tx
// PURPOSE
//  Reads a WIDTH-bit parallel word from the latch-array side (DQ4 q[0:3] bus) over a valid/ready handshake.
//  Transmits the word serially on one line as a framed bit stream: start bit, WIDTH data bits, stop bit.
//  The matching serial receiver rebuilds the word and drives a DQ4 write (d, en) at the far end.
// PARAMETERS
//  WIDTH       4   data bits per frame; bus index 0 is sent first
//  BIT_CYCLES  1   clk cycles each serial bit is held (>=1)
// PORTS
//  clk       in   1      single clock; all state updates on posedge
//  rst       in   1      synchronous, active-high reset
//  d         in   [0:WIDTH-1]  parallel word to send
//  in_valid  in   1      d is valid this cycle
//  in_ready  out  1      block can accept a word this cycle
//  tx        out  1      serial line (idle level 1)
//  busy      out  1      frame in progress
//  done      out  1      one-cycle pulse at end of stop bit
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE, tx=1, busy=0, done=0, in_ready=0 while rst=1.
//   in_ready=1 from the first cycle after rst is sampled low.
//  Accept: in_valid & in_ready at a posedge. d is copied into the internal shift register at that edge.
//   Later changes on d have no effect on the frame.
//  in_ready = (state==IDLE) & ~rst. Words presented while not ready are not accepted, and none are dropped silently.
//  FSM (all outputs registered):
//   IDLE  -> START on accept. tx=1, busy=0.
//   START -> DATA after BIT_CYCLES. tx=0, busy=1.
//   DATA  -> STOP after WIDTH*BIT_CYCLES. tx=shift[0], then shift left by one bit each BIT_CYCLES.
//            Send order: d[0], d[1], ..., d[WIDTH-1].
//   STOP  -> IDLE after BIT_CYCLES. tx=1, busy=1; done=1 in the last cycle of STOP.
//  Latency: tx falls to 0 in the cycle right after the accepting edge.
//   Frame length = (WIDTH+2)*BIT_CYCLES cycles.
//   in_ready returns high the cycle after done.
//   Back-to-back frames: minimum gap of 1 idle cycle (tx=1) between a stop bit and the next start bit.
//  Counters:
//   bit counter width = clog2(WIDTH+1); counts data bits 0..WIDTH-1.
//   cycle counter width = clog2(BIT_CYCLES+1); counts 0..BIT_CYCLES-1, clears on every bit boundary, never wraps past its limit.
//  Boundaries:
//   rst mid-frame: abort. tx=1 at the next edge, shift register and counters cleared, done not pulsed.
//   in_valid held high throughout: exactly one accept per frame, each at an IDLE cycle.
//   d containing X while not accepted: ignored. An X on tx is a bug.
//   BIT_CYCLES=1: every state lasts exactly one cycle per bit. No zero-length states.
// STRUCTURE
//  Shared package dq_pkg:
//   state encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3
//   line levels: LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1
//   default WIDTH=4
//  Sub-module bit_timer (cycle counter; emits bit_tick every BIT_CYCLES cycles; reset or restart on accept).
//  Top level holds the FSM, shift register, bit counter and output registers.
// TESTING
//  1 rst=1 for 2 cycles, then 0 -> tx=1, busy=0, done=0 throughout reset; in_ready=1 on the first cycle after reset.
//  2 BIT_CYCLES=1, d=4'b0110, in_valid 1 cycle
//    -> tx sequence 0,0,1,1,0,1 over 6 cycles; done pulses on the 6th; in_ready=1 on the 7th.
//  3 BIT_CYCLES=3, d=4'b1011
//    -> each bit held 3 cycles; 18-cycle frame; tx pattern 0,1,0,1,1,1.
//  4 in_valid held 1, d stepping 0000..1111 after each accept
//    -> 16 frames, each with the correct bit order, 1 idle cycle between frames, no word skipped or repeated.
//  5 rst asserted during DATA bit 2 of d=4'b1111
//    -> tx=1 next cycle, busy=0, no done pulse; a new word sent afterwards arrives framed correctly.
//  6 d changed mid-frame while in_valid=0
//    -> transmitted bits match the word captured at accept.

Source files
------------

// File: rtl/dq_pkg.sv
// ---------------------------------------------------------------------------
// dq_pkg
// Shared definitions for the DQ4 serial link: FSM state encoding, serial line
// levels, default parameters, and a helper that sizes counters.
// No ports (package).
// ---------------------------------------------------------------------------
package dq_pkg;

  // Frame FSM states; the encoding is fixed so the far-end receiver and any
  // debug tooling can decode a captured state value directly.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Serial line levels
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Default frame geometry
  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_BIT_CYCLES = 1;

  // Width of a counter that must be able to hold max_count.
  // Never returns less than 1 so a degenerate parameter still yields a legal vector.
  function automatic int cnt_width(input int max_count);
    int w;
    if (max_count < 1) begin
      w = 1;
    end else begin
      w = $clog2(max_count + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
// Cycle counter that measures how long each serial bit is held on the line.
// It counts 0..BIT_CYCLES-1 while the frame is running and clears itself at
// every bit boundary, so it never runs past its limit.
// Ports:
//   clk        in   clock, all updates on posedge
//   rst        in   synchronous active-high reset
//   run        in   a frame is in progress (count while high, hold 0 while low)
//   restart    in   a new word is being accepted; realign to a bit boundary
//   bit_tick   out  current cycle is the last cycle of the current bit
//   tick_next  out  the cycle after this edge will be the last cycle of a bit
// ---------------------------------------------------------------------------
module bit_timer
  import dq_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic bit_tick,
  output logic tick_next
);

  localparam int              CW   = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;

  // Next count: clear on restart, at the bit boundary, or while idle
  always_comb begin
    cnt_s = cnt_r;
    if (restart) begin
      cnt_s = '0;
    end else if (run) begin
      if (cnt_r == LAST) begin
        cnt_s = '0;
      end else begin
        cnt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_s = '0;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign bit_tick  = run & (cnt_r == LAST);
  // Look-ahead lets the top register outputs (e.g. done) that must line up
  // with the last cycle of a bit rather than trail it by one cycle.
  assign tick_next = (cnt_s == LAST);

endmodule

// File: rtl/nibble_serial_tx.sv
// ---------------------------------------------------------------------------
// nibble_serial_tx
// Accepts a WIDTH-bit word read from the DQ4 latch-array bus over a
// valid/ready handshake and sends it on a single line as a framed stream:
// start bit (0), WIDTH data bits (index 0 first), stop bit (1). Each bit is
// held BIT_CYCLES clock cycles. All outputs are registered.
// Ports:
//   clk       in   clock, all updates on posedge
//   rst       in   synchronous active-high reset (aborts any frame)
//   d         in   [0:WIDTH-1] word to send, captured at the accepting edge
//   in_valid  in   d is valid this cycle
//   in_ready  out  block can accept a word this cycle
//   tx        out  serial line, idles high
//   busy      out  frame in progress (START..STOP)
//   done      out  one-cycle pulse in the last cycle of the stop bit
// ---------------------------------------------------------------------------
module nibble_serial_tx
  import dq_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [0:WIDTH-1] shift_r;
  logic [0:WIDTH-1] shift_s;
  logic [BW-1:0]    bit_cnt_r;
  logic [BW-1:0]    bit_cnt_s;

  logic             tx_r;
  logic             busy_r;
  logic             done_r;
  logic             ready_r;
  logic             tx_s;
  logic             busy_s;
  logic             done_s;
  logic             ready_s;

  logic             accept_s;
  logic             run_s;
  logic             bit_tick_s;
  logic             tick_next_s;

  // ready_r is only high in IDLE outside reset, so this is exactly the handshake
  assign accept_s = in_valid & ready_r;
  assign run_s    = (state_r != IDLE);

  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run_s),
    .restart   (accept_s),
    .bit_tick  (bit_tick_s),
    .tick_next (tick_next_s)
  );

  // Next-state logic for the frame FSM, shift register and bit counter
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s   = START;
          shift_s   = d;
          bit_cnt_s = '0;
        end else begin
          state_s   = IDLE;
        end
      end
      START: begin
        if (bit_tick_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_tick_s) begin
          // Index 0 is the ascending-range MSB, so a left shift brings
          // the next bit to send into shift[0].
          shift_s = shift_r << 1;
          if (bit_cnt_r == LAST_BIT) begin
            state_s   = STOP;
            bit_cnt_s = '0;
          end else begin
            state_s   = DATA;
            bit_cnt_s = bit_cnt_r + BW'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (bit_tick_s) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        shift_s   = '0;
        bit_cnt_s = '0;
      end
    endcase
  end

  // Output values for the cycle after this edge, derived from the next state
  // so the registered outputs line up with the state they describe.
  always_comb begin
    tx_s    = LINE_IDLE;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    ready_s = 1'b0;
    case (state_s)
      IDLE: begin
        tx_s    = LINE_IDLE;
        ready_s = 1'b1;
      end
      START: begin
        tx_s   = START_LVL;
        busy_s = 1'b1;
      end
      DATA: begin
        tx_s   = shift_s[0];
        busy_s = 1'b1;
      end
      STOP: begin
        tx_s   = STOP_LVL;
        busy_s = 1'b1;
        done_s = tick_next_s;
      end
      default: begin
        tx_s    = LINE_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        ready_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      tx_r      <= LINE_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      ready_r   <= ready_s;
    end
  end

  assign tx       = tx_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign in_ready = ready_r;

endmodule
